imgstat: RTL

Per-frame statistics collector that sits directly downstream of the pixel encoder/adjust stage. It consumes the encoder's registered 8-bit output pixel stream and accumulates pixel count, min, max, sum, mean, and saturated/zero counts over a fixed IMG_W × IMG_H frame. It presents one result set per frame on a valid/ready output port. It exists to check brighten/darken/threshold/invert settings on real frames without capturing the whole image.

---
 rtl/imgstat_pkg.sv | 34 +++
 rtl/imgstat_if.sv | 39 +++
 rtl/imgstat_accum.sv | 94 +++++++++
 rtl/imgstat.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/imgstat_pkg.sv
// imgproc_pkg: shared definitions for the image-statistics block.
//   PIX_W / PIX_MAX / PIX_MIN : pixel width and the saturated / zero codes.
//   acc_state_e               : accumulator FSM state encoding.
//   log2_f                    : ceil(log2(n)); exact for the power-of-two
//                               frame sizes used here.
package imgproc_pkg;

  localparam int         PIX_W   = 8;
  localparam logic [7:0] PIX_MAX = 8'hFF;
  localparam logic [7:0] PIX_MIN = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  // Smallest r with 2**r >= n; evaluated at elaboration for port widths.
  function automatic int log2_f(input int n);
    int r;
    int p;
    r = 32'sd0;
    p = 32'sd1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) begin
        r = r + 32'sd1;
        p = p + p;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/imgstat_if.sv
// imgstat_if: pixel input stream plus the result valid/ready port.
//   pix_valid / pix / sof : encoder pixel stream (no backpressure); pix bit 0
//                           is the MSB, matching the encoder output bus.
//   stats_valid / stats_ready and st_* : one result set per frame.
// Modports: slave = statistics block, master = pixel source / result consumer.
interface imgstat_if
  import imgproc_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
);
  localparam int NW = log2_f(IMG_W * IMG_H);
  localparam int SW = PIX_W + NW;
  localparam int CW = NW + 1;

  logic             pix_valid;
  logic [0:PIX_W-1] pix;
  logic             sof;

  logic             stats_valid;
  logic             stats_ready;
  logic [0:PIX_W-1] st_min;
  logic [0:PIX_W-1] st_max;
  logic [0:PIX_W-1] st_mean;
  logic [SW-1:0]    st_sum;
  logic [CW-1:0]    st_sat_cnt;
  logic [CW-1:0]    st_zero_cnt;

  modport slave (
    input  pix_valid, pix, sof, stats_ready,
    output stats_valid, st_min, st_max, st_mean, st_sum, st_sat_cnt, st_zero_cnt
  );

  modport master (
    output pix_valid, pix, sof, stats_ready,
    input  stats_valid, st_min, st_max, st_mean, st_sum, st_sat_cnt, st_zero_cnt
  );

endinterface

// File: rtl/imgstat_accum.sv
// imgstat_accum: per-frame pixel datapath (count, sum, min, max, sat, zero).
//   clk, rst     : clock and synchronous active-high reset.
//   load_i       : restart the accumulators from pix_i (first pixel of frame).
//   update_i     : fold pix_i into the running values.
//   pix_i        : pixel value.
//   upd_*_o      : running values with pix_i already folded in; the top
//                  publishes these on the last pixel so that pixel counts.
module imgstat_accum
  import imgproc_pkg::*;
#(
  parameter int CW = 4,
  parameter int SW = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             update_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [CW-1:0]    upd_cnt_o,
  output logic [SW-1:0]    upd_sum_o,
  output logic [PIX_W-1:0] upd_min_o,
  output logic [PIX_W-1:0] upd_max_o,
  output logic [CW-1:0]    upd_sat_o,
  output logic [CW-1:0]    upd_zero_o
);

  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [SW-1:0]    sum_q,  sum_d;
  logic [PIX_W-1:0] min_q,  min_d;
  logic [PIX_W-1:0] max_q,  max_d;
  logic [CW-1:0]    sat_q,  sat_d;
  logic [CW-1:0]    zero_q, zero_d;
  logic             is_sat_s;
  logic             is_zero_s;

  // Running values including the current pixel.
  always_comb begin
    is_sat_s   = (pix_i == PIX_MAX);
    is_zero_s  = (pix_i == PIX_MIN);
    upd_cnt_o  = cnt_q + CW'(1'b1);
    upd_sum_o  = sum_q + SW'(pix_i);
    upd_min_o  = (pix_i < min_q) ? pix_i : min_q;
    upd_max_o  = (pix_i > max_q) ? pix_i : max_q;
    upd_sat_o  = sat_q + CW'(is_sat_s);
    upd_zero_o = zero_q + CW'(is_zero_s);
  end

  // Next-state selection: load a fresh frame, update, or hold.
  always_comb begin
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    min_d  = min_q;
    max_d  = max_q;
    sat_d  = sat_q;
    zero_d = zero_q;
    if (load_i) begin
      cnt_d  = CW'(1'b1);
      sum_d  = SW'(pix_i);
      min_d  = pix_i;
      max_d  = pix_i;
      sat_d  = CW'(is_sat_s);
      zero_d = CW'(is_zero_s);
    end else if (update_i) begin
      cnt_d  = upd_cnt_o;
      sum_d  = upd_sum_o;
      min_d  = upd_min_o;
      max_d  = upd_max_o;
      sat_d  = upd_sat_o;
      zero_d = upd_zero_o;
    end else begin
      cnt_d  = cnt_q;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      min_q  <= '0;
      max_q  <= '0;
      sat_q  <= '0;
      zero_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      min_q  <= min_d;
      max_q  <= max_d;
      sat_q  <= sat_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: rtl/imgstat.sv
// imgstat: per-frame statistics collector for the encoder output stream.
//   clk, rst : single clock, synchronous active-high reset.
//   bus      : imgstat_if.slave -- pixel stream in, result set out with
//              valid/ready handshake (st_min/max/mean/sum/sat_cnt/zero_cnt).
//   err_sync : one-cycle pulse when a pixel is dropped for lack of sof or a
//              partial frame is discarded by an early sof.
//   overrun  : one-cycle pulse when an unaccepted result is overwritten.
// The accumulator FSM and the output register are independent, so the next
// frame accumulates while a result waits for the consumer.
module imgstat
  import imgproc_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic      clk,
  input  logic      rst,
  imgstat_if.slave  bus,
  output logic      err_sync,
  output logic      overrun
);

  localparam int N  = IMG_W * IMG_H;
  localparam int NW = log2_f(N);
  localparam int SW = PIX_W + NW;
  localparam int CW = NW + 1;
  localparam logic [CW-1:0] N_CNT = CW'(N);

  acc_state_e       state_q, state_d;
  logic             load_s, update_s, publish_s;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic [PIX_W-1:0] pix_s;

  logic [CW-1:0]    upd_cnt_s, upd_sat_s, upd_zero_s;
  logic [SW-1:0]    upd_sum_s;
  logic [PIX_W-1:0] upd_min_s, upd_max_s;

  logic             valid_q, valid_d;
  logic [PIX_W-1:0] min_q, min_d, max_q, max_d, mean_q, mean_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [CW-1:0]    sat_q, sat_d, zero_q, zero_d;

  assign pix_s = bus.pix;

  imgstat_accum #(.CW(CW), .SW(SW)) u_accum (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .update_i   (update_s),
    .pix_i      (pix_s),
    .upd_cnt_o  (upd_cnt_s),
    .upd_sum_o  (upd_sum_s),
    .upd_min_o  (upd_min_s),
    .upd_max_o  (upd_max_s),
    .upd_sat_o  (upd_sat_s),
    .upd_zero_o (upd_zero_s)
  );

  // Accumulator FSM: frame start, pixel folding, publish and framing errors.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    update_s  = 1'b0;
    publish_s = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pix_valid) begin
          if (bus.sof) begin
            load_s  = 1'b1;
            state_d = ST_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bus.pix_valid) begin
          if (bus.sof) begin
            // Early sof: drop the partial frame and restart from this pixel.
            load_s = 1'b1;
            err_d  = 1'b1;
          end else begin
            update_s = 1'b1;
            if (upd_cnt_s == N_CNT) begin
              publish_s = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_ACCUM;
            end
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result register and handshake; publish takes priority over consumption.
  always_comb begin
    valid_d = valid_q;
    min_d   = min_q;
    max_d   = max_q;
    mean_d  = mean_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    zero_d  = zero_q;
    ovr_d   = 1'b0;
    if (publish_s) begin
      valid_d = 1'b1;
      min_d   = upd_min_s;
      max_d   = upd_max_s;
      sum_d   = upd_sum_s;
      // N is a power of two, so the mean is the top PIX_W bits of the sum.
      mean_d  = upd_sum_s[SW-1:NW];
      sat_d   = upd_sat_s;
      zero_d  = upd_zero_s;
      ovr_d   = valid_q & ~bus.stats_ready;
    end else if (valid_q && bus.stats_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, pulse and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      mean_q  <= '0;
      sum_q   <= '0;
      sat_q   <= '0;
      zero_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mean_q  <= mean_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.stats_valid = valid_q;
  assign bus.st_min      = min_q;
  assign bus.st_max      = max_q;
  assign bus.st_mean     = mean_q;
  assign bus.st_sum      = sum_q;
  assign bus.st_sat_cnt  = sat_q;
  assign bus.st_zero_cnt = zero_q;
  assign err_sync        = err_q;
  assign overrun         = ovr_q;

endmodule
